// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcodes, IR field
// positions, FSM states and opcode classes.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_SHR = 5'b00111;
    localparam logic [4:0] OP_SHL = 5'b01000;
    localparam logic [4:0] OP_ROR = 5'b01001;
    localparam logic [4:0] OP_ROL = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;

    localparam int OPC_LSB = 27;
    localparam int RA_LSB  = 23;
    localparam int RB_LSB  = 19;
    localparam int RC_LSB  = 15;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        CLS_BIN, CLS_UNARY, CLS_MULDIV, CLS_ILLEGAL
    } cls_e;

    function automatic cls_e op_class(input logic [4:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CLS_BIN;
            OP_MUL, OP_DIV:                 return CLS_MULDIV;
            OP_NEG, OP_NOT:                 return CLS_UNARY;
            default:                        return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Handshake and strobe bundle between the sequencer (master) and the
// datapath/memory side (slave).
interface alu_instr_sequencer_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int OPC_W    = 5
);
    logic                start;
    logic                mem_ready;
    logic [DATA_W-1:0]   ir;
    logic                pc_out, zlow_out, zhigh_out, mdr_out;
    logic                mar_in, pc_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
    logic                inc_pc, read;
    logic [NUM_REGS-1:0] reg_out, reg_in;
    logic [OPC_W-1:0]    alu_op;
    logic                busy, done, illegal, mem_err;

    modport master (
        input  start, mem_ready, ir,
        output pc_out, zlow_out, zhigh_out, mdr_out,
               mar_in, pc_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in,
               inc_pc, read, reg_out, reg_in, alu_op,
               busy, done, illegal, mem_err
    );

    modport slave (
        output start, mem_ready, ir,
        input  pc_out, zlow_out, zhigh_out, mdr_out,
               mar_in, pc_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in,
               inc_pc, read, reg_out, reg_in, alu_op,
               busy, done, illegal, mem_err
    );
endinterface

// File: rtl/instr_decode.sv
// Combinational IR decode: opcode class plus one-hot register selects.
module instr_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 4,
    parameter int OPC_W     = 5
) (
    input  logic [DATA_W-1:0]   ir,
    output logic [OPC_W-1:0]    opc,
    output cls_e                cls,
    output logic [NUM_REGS-1:0] ra_oh,
    output logic [NUM_REGS-1:0] rb_oh,
    output logic [NUM_REGS-1:0] rc_oh
);
    logic [REG_IDX_W-1:0] ra, rb, rc;
    logic [4:0]           op5;
    logic                 reg_bad;
    logic                 unused;

    assign opc    = ir[OPC_LSB +: OPC_W];
    assign ra     = ir[RA_LSB  +: REG_IDX_W];
    assign rb     = ir[RB_LSB  +: REG_IDX_W];
    assign rc     = ir[RC_LSB  +: REG_IDX_W];
    assign unused = ^ir[RC_LSB-1:0];

    assign op5     = 5'(opc);
    assign reg_bad = (int'(ra) >= NUM_REGS) || (int'(rb) >= NUM_REGS) ||
                     (int'(rc) >= NUM_REGS);
    // An opcode wider than the table's 5 bits is only legal if it round-trips.
    assign cls = (reg_bad || OPC_W'(op5) != opc) ? CLS_ILLEGAL : op_class(op5);

    assign ra_oh = NUM_REGS'(1) << ra;
    assign rb_oh = NUM_REGS'(1) << rb;
    assign rc_oh = NUM_REGS'(1) << rc;
endmodule

// File: rtl/alu_instr_sequencer.sv
// Hard-wired fetch/decode/execute controller for register-register and unary
// ALU instructions, with memory-ready timeout and multi-cycle MUL/DIV.
module alu_instr_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int NUM_REGS      = 16,
    parameter int REG_IDX_W     = 4,
    parameter int OPC_W         = 5,
    parameter int MULDIV_CYCLES = 1,
    parameter int MEM_TIMEOUT   = 8
) (
    input logic                  clk,
    input logic                  clr,
    alu_instr_sequencer_if.master bus
);
    localparam int CNT_MAX = (MEM_TIMEOUT > MULDIV_CYCLES) ? MEM_TIMEOUT : MULDIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MD_LAST  = CNT_W'(MULDIV_CYCLES - 1);

    state_e              state;
    logic [CNT_W-1:0]    cnt;
    logic                mem_err_q;
    logic [OPC_W-1:0]    opc;
    cls_e                cls;
    logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;

    instr_decode #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W), .OPC_W(OPC_W)
    ) u_dec (
        .ir(bus.ir), .opc(opc), .cls(cls), .ra_oh(ra_oh), .rb_oh(rb_oh), .rc_oh(rc_oh)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mem_err_q <= 1'b0;
        end else begin
            mem_err_q <= 1'b0;
            cnt       <= cnt + CNT_W'(1);
            case (state)
                S_IDLE: if (bus.start) state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1: begin
                    state <= S_T1W;
                    cnt   <= '0;
                end
                S_T1W: begin
                    if (bus.mem_ready) begin
                        state <= S_T2;
                    end else if (cnt == TMO_LAST) begin
                        state     <= S_IDLE;
                        mem_err_q <= 1'b1;
                    end
                end
                S_T2:   state <= S_T3;
                S_T3: begin
                    cnt <= '0;
                    case (cls)
                        CLS_ILLEGAL: state <= S_IDLE;
                        CLS_UNARY:   state <= S_T5;
                        default:     state <= S_T4;
                    endcase
                end
                S_T4:   if (cls != CLS_MULDIV || cnt == MD_LAST) state <= S_T5;
                S_T5:   state <= (cls == CLS_MULDIV) ? S_T6 : S_DONE;
                S_T6:   state <= S_DONE;
                S_DONE: state <= bus.start ? S_T0 : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes come from the registered state; ir is stable from T3 onward
    // because it was loaded at the end of T2.
    always_comb begin
        bus.pc_out    = 1'b0;
        bus.zlow_out  = 1'b0;
        bus.zhigh_out = 1'b0;
        bus.mdr_out   = 1'b0;
        bus.mar_in    = 1'b0;
        bus.pc_in     = 1'b0;
        bus.mdr_in    = 1'b0;
        bus.ir_in     = 1'b0;
        bus.y_in      = 1'b0;
        bus.z_in      = 1'b0;
        bus.hi_in     = 1'b0;
        bus.lo_in     = 1'b0;
        bus.inc_pc    = 1'b0;
        bus.read      = 1'b0;
        bus.reg_out   = '0;
        bus.reg_in    = '0;
        bus.alu_op    = '0;
        bus.done      = 1'b0;
        bus.illegal   = 1'b0;
        bus.busy      = (state != S_IDLE);
        bus.mem_err   = mem_err_q;
        case (state)
            S_T0: begin
                bus.pc_out = 1'b1;
                bus.mar_in = 1'b1;
                bus.inc_pc = 1'b1;
                bus.z_in   = 1'b1;
            end
            S_T1: begin
                bus.zlow_out = 1'b1;
                bus.pc_in    = 1'b1;
                bus.read     = 1'b1;
            end
            S_T1W: begin
                bus.read   = 1'b1;
                bus.mdr_in = bus.mem_ready;
            end
            S_T2: begin
                bus.mdr_out = 1'b1;
                bus.ir_in   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CLS_ILLEGAL: bus.illegal = 1'b1;
                    CLS_UNARY: begin
                        bus.reg_out = rb_oh;
                        bus.alu_op  = opc;
                        bus.z_in    = 1'b1;
                    end
                    default: begin
                        bus.reg_out = rb_oh;
                        bus.y_in    = 1'b1;
                    end
                endcase
            end
            S_T4: begin
                bus.reg_out = rc_oh;
                bus.alu_op  = opc;
                bus.z_in    = (cls != CLS_MULDIV) || (cnt == MD_LAST);
            end
            S_T5: begin
                bus.zlow_out = 1'b1;
                if (cls == CLS_MULDIV) bus.lo_in  = 1'b1;
                else                   bus.reg_in = ra_oh;
            end
            S_T6: begin
                bus.zhigh_out = 1'b1;
                bus.hi_in     = 1'b1;
            end
            S_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer: table of whole-instruction vectors
// plus hand-written sequences for timeout, reset, MUL timing and back-to-back.
module tb_alu_instr_sequencer;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    alu_instr_sequencer_if #(.DATA_W(32), .NUM_REGS(16), .OPC_W(5)) bus();

    alu_instr_sequencer #(
        .DATA_W(32), .NUM_REGS(16), .REG_IDX_W(4), .OPC_W(5),
        .MULDIV_CYCLES(4), .MEM_TIMEOUT(8)
    ) dut (
        .clk(clk), .clr(clr), .bus(bus)
    );

    logic any_out;
    assign any_out = |{bus.pc_out, bus.zlow_out, bus.zhigh_out, bus.mdr_out,
                       bus.mar_in, bus.pc_in, bus.mdr_in, bus.ir_in, bus.y_in,
                       bus.z_in, bus.hi_in, bus.lo_in, bus.inc_pc, bus.read,
                       bus.reg_out, bus.reg_in, bus.alu_op,
                       bus.busy, bus.done, bus.illegal, bus.mem_err};

    int n_cmp = 0;
    int n_bad = 0;

    // Per-run record, filled by sample().
    int          ev_kind, ev_cyc, n_zin, n_yin, n_irin, n_mdrin, n_t1w, n_op, n_lohi;
    int          last_zin, lo_cyc, hi_cyc, excl, busy_after;
    logic [15:0] rout_or, rin_or;
    logic [4:0]  op_or;

    // ev kinds: 1 done, 2 illegal, 3 mem_err
    typedef struct {
        string       name;
        logic [31:0] ir;
        int          dly;
        int          kind;
        int          lat;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  op;
        int          nz;
        int          ny;
        int          nlohi;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample(input int c);
        int src;
        if (bus.z_in) begin n_zin++; last_zin = c; end
        n_yin   += int'(bus.y_in);
        n_irin  += int'(bus.ir_in);
        n_mdrin += int'(bus.mdr_in);
        if (bus.read && !bus.pc_in) n_t1w++;
        rout_or |= bus.reg_out;
        rin_or  |= bus.reg_in;
        op_or   |= bus.alu_op;
        if (bus.alu_op != 0) n_op++;
        if (bus.lo_in) lo_cyc = c;
        if (bus.hi_in) hi_cyc = c;
        n_lohi += int'(bus.lo_in) + int'(bus.hi_in);
        src = int'(bus.pc_out) + int'(bus.zlow_out) + int'(bus.zhigh_out) +
              int'(bus.mdr_out) + int'(bus.reg_out != 0);
        if (src > 1 || !$onehot0(bus.reg_out) || !$onehot0(bus.reg_in)) excl++;
        if (ev_kind == 0) begin
            if (bus.done)         begin ev_kind = 1; ev_cyc = c; end
            else if (bus.illegal) begin ev_kind = 2; ev_cyc = c; end
            else if (bus.mem_err) begin ev_kind = 3; ev_cyc = c; end
        end
    endtask

    task automatic clear_rec();
        ev_kind = 0; ev_cyc = -1; n_zin = 0; n_yin = 0; n_irin = 0; n_mdrin = 0;
        n_t1w = 0; n_op = 0; n_lohi = 0; last_zin = -1; lo_cyc = -1; hi_cyc = -1;
        excl = 0; rout_or = '0; rin_or = '0; op_or = '0; busy_after = -1;
    endtask

    // Cycle c is the cycle after the c-th rising edge following the start edge.
    // dly < 0 means mem_ready never arrives.
    task automatic run(input logic [31:0] instr, input int dly);
        clear_rec();
        @(negedge clk);
        bus.ir    = instr;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 40 && ev_kind == 0; c++) begin
            @(negedge clk);
            bus.mem_ready = (dly >= 0) && (c >= 3 + dly);
            #1;
            sample(c);
        end
        bus.mem_ready = 1'b0;
        if (ev_kind != 3) begin
            @(negedge clk);
            #1;
        end
        busy_after = int'(bus.busy);
    endtask

    vec_t vecs[9];

    initial begin
        bus.start = 1'b0; bus.mem_ready = 1'b0; bus.ir = '0;
        vecs[0] = '{"and_r1_r2_r3", 32'h28918000, 0, 1, 8,  16'h000C, 16'h0002, 5'b00101, 2, 1, 0};
        vecs[1] = '{"neg_r6_r7",    32'h83380000, 0, 1, 7,  16'h0080, 16'h0040, 5'b10000, 2, 0, 0};
        vecs[2] = '{"mul_r0_r2_r3", 32'h70118000, 0, 1, 12, 16'h000C, 16'h0000, 5'b01110, 2, 1, 2};
        vecs[3] = '{"sub_dly2",     32'h222B0000, 2, 1, 10, 16'h0060, 16'h0010, 5'b00100, 2, 1, 0};
        vecs[4] = '{"div_dly1",     32'h7FF68000, 1, 1, 13, 16'h6000, 16'h0000, 5'b01111, 2, 1, 2};
        vecs[5] = '{"not_r15_r0",   32'h8F800000, 0, 1, 7,  16'h0001, 16'h8000, 5'b10001, 2, 0, 0};
        vecs[6] = '{"rol_r0_r15",   32'h507F8000, 0, 1, 8,  16'h8000, 16'h0001, 5'b01010, 2, 1, 0};
        vecs[7] = '{"ill_f8",       32'hF8000000, 0, 2, 5,  16'h0000, 16'h0000, 5'b00000, 1, 0, 0};
        vecs[8] = '{"ill_op0b",     32'h58000000, 0, 2, 5,  16'h0000, 16'h0000, 5'b00000, 1, 0, 0};

        // Reset holds everything low even with start asserted.
        #12;
        chk("reset_outs", 32'(any_out), 32'd0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        chk("reset_start_ignored", 32'(any_out), 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk); #1;
        chk("idle_outs", 32'(any_out), 32'd0);

        foreach (vecs[i]) begin
            run(vecs[i].ir, vecs[i].dly);
            chk({vecs[i].name, "_kind"},  32'(ev_kind),  32'(vecs[i].kind));
            chk({vecs[i].name, "_lat"},   32'(ev_cyc),   32'(vecs[i].lat));
            chk({vecs[i].name, "_rout"},  32'(rout_or),  32'(vecs[i].rout));
            chk({vecs[i].name, "_rin"},   32'(rin_or),   32'(vecs[i].rin));
            chk({vecs[i].name, "_op"},    32'(op_or),    32'(vecs[i].op));
            chk({vecs[i].name, "_nz"},    32'(n_zin),    32'(vecs[i].nz));
            chk({vecs[i].name, "_ny"},    32'(n_yin),    32'(vecs[i].ny));
            chk({vecs[i].name, "_lohi"},  32'(n_lohi),   32'(vecs[i].nlohi));
            chk({vecs[i].name, "_mdrin"}, 32'(n_mdrin),  32'd1);
            chk({vecs[i].name, "_t1w"},   32'(n_t1w),    32'(vecs[i].dly + 1));
            chk({vecs[i].name, "_excl"},  32'(excl),     32'd0);
            chk({vecs[i].name, "_idle"},  32'(busy_after), 32'd0);
        end

        // MUL: T4 spans cycles 6..9, z_in only in the last, then LO and HI.
        run(32'h70118000, 0);
        chk("mul_op_cycles", 32'(n_op),     32'd4);
        chk("mul_zin_cyc",   32'(last_zin), 32'd9);
        chk("mul_lo_cyc",    32'(lo_cyc),   32'd10);
        chk("mul_hi_cyc",    32'(hi_cyc),   32'd11);

        // mem_ready never arrives: 8 cycles of T1W then mem_err while idle.
        run(32'h28918000, -1);
        chk("tmo_kind",  32'(ev_kind),    32'd3);
        chk("tmo_cyc",   32'(ev_cyc),     32'd11);
        chk("tmo_t1w",   32'(n_t1w),      32'd8);
        chk("tmo_irin",  32'(n_irin),     32'd0);
        chk("tmo_busy",  32'(busy_after), 32'd0);
        @(negedge clk); #1;
        chk("tmo_pulse_end", 32'(bus.mem_err), 32'd0);

        // Asynchronous reset in the middle of T4.
        clear_rec();
        @(negedge clk);
        bus.ir = 32'h28918000; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.mem_ready = (c >= 3);
            #1;
        end
        bus.mem_ready = 1'b0;
        chk("t4_before_clr", {30'd0, bus.z_in, bus.reg_out == 16'h0008}, 32'd3);
        #2 clr = 1'b0;
        #1 chk("clr_mid_t4", 32'(any_out), 32'd0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk); #1;
        chk("clr_recover_idle", 32'(any_out), 32'd0);

        // start held high across two ANDs: T0 directly follows DONE.
        clear_rec();
        @(negedge clk);
        bus.ir = 32'h28918000; bus.start = 1'b1; bus.mem_ready = 1'b1;
        begin
            int d1, d2, t0_after;
            d1 = -1; d2 = -1; t0_after = 0;
            @(posedge clk);
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk); #1;
                if (bus.done && d1 < 0) d1 = c;
                else if (bus.done && d2 < 0) d2 = c;
                if (c == 9) t0_after = int'(bus.pc_out && bus.busy);
                if (c == 16) bus.start = 1'b0;
            end
            bus.mem_ready = 1'b0;
            chk("b2b_done1",  32'(d1), 32'd8);
            chk("b2b_done2",  32'(d2), 32'd16);
            chk("b2b_t0",     32'(t0_after), 32'd1);
            chk("b2b_idle",   32'(bus.busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
